sram_burst_ctrl: RTL and testbench

Parametrised controller between the MEM stage and the off-chip asynchronous 16-bit SRAM. It performs single-word writes with byte masking and multi-word line reads (cache-line fill) as timed beat sequences. It holds `ready` low to freeze the pipeline while busy. It generalises data width, line length, base address and SRAM access time over the fixed 32/64-bit, zero-wait controller.

---
 rtl/sram_burst_ctrl_pkg.sv | 31 +++
 rtl/sram_beat_timer.sv | 40 ++++
 rtl/sram_burst_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types, default parameters and sizing helpers for the SRAM burst controller.
package sram_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_SRAM_DW     = 16;
    localparam int unsigned DEF_SRAM_AW     = 18;
    localparam int unsigned DEF_LINE_WORDS  = 2;
    localparam int unsigned DEF_WAIT_CYCLES = 0;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (clog2(max_val + 1) == 0) ? 1 : clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-state and beat counters that pace one SRAM burst while run is high.
module sram_beat_timer
    import sram_burst_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned MAX_BEATS   = 4,
    localparam int unsigned BW         = cnt_w(MAX_BEATS - 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [BW-1:0] last_beat,
    output logic [BW-1:0] beat,
    output logic          beat_last_cycle,
    output logic          burst_done
);

    localparam int unsigned WW = cnt_w(WAIT_CYCLES);

    logic [WW-1:0] wait_cnt;

    assign beat_last_cycle = (wait_cnt == WW'(WAIT_CYCLES));
    assign burst_done      = beat_last_cycle && (beat == last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (!run) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (beat_last_cycle) begin
            wait_cnt <= '0;
            beat     <= burst_done ? '0 : beat + 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// MEM-stage controller for an asynchronous 16-bit SRAM: masked single-word
// writes and line-fill reads as timed beat sequences, stalling via ready.
module sram_burst_ctrl
    import sram_burst_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SRAM_DW     = DEF_SRAM_DW,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
    parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [31:0]                  address,
    input  logic [DATA_W-1:0]            write_data,
    input  logic [DATA_W/8-1:0]          byte_en,
    output logic [LINE_WORDS*DATA_W-1:0] read_data,
    output logic                         ready,
    inout  logic [SRAM_DW-1:0]           SRAM_DQ,
    output logic [SRAM_AW-1:0]           SRAM_ADDR,
    output logic                         SRAM_UB_N,
    output logic                         SRAM_LB_N,
    output logic                         SRAM_WE_N,
    output logic                         SRAM_CE_N,
    output logic                         SRAM_OE_N
);

    localparam int unsigned RATIO       = DATA_W / SRAM_DW;
    localparam int unsigned WR_BEATS    = RATIO;
    localparam int unsigned RD_BEATS    = LINE_WORDS * RATIO;
    localparam int unsigned BW          = cnt_w(RD_BEATS - 1);
    localparam int unsigned BYTE_SH     = clog2(DATA_W / 8);
    localparam int unsigned SLICE_BYTES = SRAM_DW / 8;

    state_t                  state, state_nx;
    logic                    op_wr;
    logic [SRAM_AW-1:0]      base;
    logic [DATA_W-1:0]       wdata;
    logic [DATA_W/8-1:0]     ben;
    logic [BW-1:0]           beat, last_beat;
    logic                    beat_last_cycle, burst_done;
    logic [SRAM_DW-1:0]      wslice;
    logic [SLICE_BYTES-1:0]  bslice;
    logic                    drive;
    logic [31:0]             word_addr, req_word;
    logic [31:0]             line_mask;

    assign line_mask = ~(32'(LINE_WORDS) - 32'd1);
    assign word_addr = (address - BASE_ADDR) >> BYTE_SH;
    // A write wins over a simultaneous read, so only pure reads are line-aligned.
    assign req_word  = wr_en ? word_addr : (word_addr & line_mask);
    assign last_beat = op_wr ? BW'(WR_BEATS - 1) : BW'(RD_BEATS - 1);

    sram_beat_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .MAX_BEATS   (RD_BEATS)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .run             (state == ACCESS),
        .last_beat       (last_beat),
        .beat            (beat),
        .beat_last_cycle (beat_last_cycle),
        .burst_done      (burst_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (wr_en || rd_en) state_nx = ACCESS;
            ACCESS:  if (burst_done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr <= 1'b0;
            base  <= '0;
            wdata <= '0;
            ben   <= '0;
        end else if (state == IDLE && (wr_en || rd_en)) begin
            op_wr <= wr_en;
            base  <= SRAM_AW'(req_word * RATIO);
            wdata <= write_data;
            ben   <= byte_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (state == ACCESS && !op_wr && beat_last_cycle) begin
            for (int unsigned i = 0; i < RD_BEATS; i++) begin
                if (beat == BW'(i)) read_data[i*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        wslice = '0;
        bslice = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (beat == BW'(i)) begin
                wslice = wdata[i*SRAM_DW +: SRAM_DW];
                bslice = ben[i*SLICE_BYTES +: SLICE_BYTES];
            end
        end
    end

    always_comb begin
        ready     = 1'b0;
        drive     = 1'b0;
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        case (state)
            IDLE:   ready = !rst && !(wr_en || rd_en);
            DONE:   ready = 1'b1;
            ACCESS: begin
                SRAM_CE_N = 1'b0;
                if (op_wr) begin
                    drive     = 1'b1;
                    SRAM_UB_N = ~bslice[SLICE_BYTES-1];
                    SRAM_LB_N = ~bslice[0];
                    SRAM_WE_N = (bslice == '0);
                end else begin
                    SRAM_OE_N = 1'b0;
                    SRAM_UB_N = 1'b0;
                    SRAM_LB_N = 1'b0;
                end
            end
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_ADDR = base + SRAM_AW'(beat);
    assign SRAM_DQ   = drive ? wslice : 'z;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench: directed requests queue expected bus beats and completions,
// independent monitors compare them against the two controller instances.
module tb_sram_burst_ctrl;

    typedef struct packed {
        logic        id;
        logic [17:0] addr;
        logic [3:0]  ctrl;   // {we_n, oe_n, ub_n, lb_n}
        logic        drv;
        logic [15:0] dq;
    } beat_t;

    typedef struct packed {
        logic        id;
        logic [63:0] rd;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr1 = 1'b0, rd1 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;
    logic [31:0] addr1 = '0, addr2 = '0, wd1 = '0, wd2 = '0;
    logic [3:0]  be1 = '0, be2 = '0;
    logic [63:0] rdata1, rdata2;
    logic        ready1, ready2;
    wire  [15:0] dq1, dq2;
    logic [17:0] sa1, sa2;
    logic        ub1, lb1, we1, ce1, oe1, ub2, lb2, we2, ce2, oe2;

    sram_burst_ctrl u_dut (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
        .write_data(wd1), .byte_en(be1), .read_data(rdata1), .ready(ready1),
        .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1),
        .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    sram_burst_ctrl #(.WAIT_CYCLES(2)) u_dut_wait (
        .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .address(addr2),
        .write_data(wd2), .byte_en(be2), .read_data(rdata2), .ready(ready2),
        .SRAM_DQ(dq2), .SRAM_ADDR(sa2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2),
        .SRAM_WE_N(we2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
    );

    // Asynchronous SRAM behaviour for the default instance.
    logic [15:0] mem [0:1023];
    assign dq1 = (!ce1 && !oe1 && we1) ? mem[sa1[9:0]] : 'z;

    always @(negedge clk) begin
        if (!rst && !ce1 && !we1) begin
            if (!lb1) mem[sa1[9:0]][7:0]  <= dq1[7:0];
            if (!ub1) mem[sa1[9:0]][15:8] <= dq1[15:8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic id, input logic [17:0] a, input logic [3:0] ctrl,
                             input logic drv, input logic [15:0] dq);
        beat_t b;
        b.id = id; b.addr = a; b.ctrl = ctrl; b.drv = drv; b.dq = dq;
        beat_q.push_back(b);
    endtask

    task automatic exp_write(input logic id, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input int unsigned hold, input logic [63:0] rd_keep);
        logic [31:0] w;
        logic [1:0]  bs;
        done_t       dn;
        w = (a - 32'd1024) >> 2;
        for (int unsigned k = 0; k < 2; k++) begin
            bs = be[2*k +: 2];
            for (int unsigned h = 0; h < hold; h++)
                push_beat(id, 18'(w * 2 + k), {(bs == 2'b00), 1'b1, ~bs[1], ~bs[0]}, 1'b1, d[16*k +: 16]);
        end
        dn.id = id; dn.rd = rd_keep;
        done_q.push_back(dn);
    endtask

    task automatic exp_read(input logic [31:0] a, input logic [63:0] line, input int unsigned nbeats);
        logic [31:0] w;
        done_t       dn;
        w = ((a - 32'd1024) >> 2) & ~32'd1;
        for (int unsigned k = 0; k < nbeats; k++)
            push_beat(1'b0, 18'(w * 2 + k), 4'b1000, 1'b0, 16'h0);
        if (nbeats == 4) begin
            dn.id = 1'b0; dn.rd = line;
            done_q.push_back(dn);
        end
    endtask

    task automatic run_op(input logic id, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input int unsigned lat);
        int unsigned n;
        @(posedge clk); #1;
        if (id) begin wr2 = w; rd2 = r; addr2 = a; wd2 = d; be2 = be; end
        else    begin wr1 = w; rd1 = r; addr1 = a; wd1 = d; be1 = be; end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(id ? ready2 : ready1) && n < 40);
        chk("latency", 64'(n), 64'(lat));
        wr1 = 1'b0; rd1 = 1'b0; wr2 = 1'b0; rd2 = 1'b0;
    endtask

    task automatic mon(input logic id, input logic ce_n, input logic [3:0] ctrl,
                       input logic [17:0] a, input logic [15:0] dq, input logic rdy,
                       input logic [63:0] rdata, input logic prev_ce_n);
        beat_t b;
        done_t d;
        if (!ce_n) begin
            if (beat_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat_unexpected id=%0d actual addr=%h required=no beat", id, a);
            end else begin
                b = beat_q.pop_front();
                chk("beat_id", 64'(id), 64'(b.id));
                chk("sram_addr", 64'(a), 64'(b.addr));
                chk("sram_ctrl", 64'(ctrl), 64'(b.ctrl));
                chk("ready_busy", 64'(rdy), 64'd0);
                if (b.drv) chk("sram_dq", 64'(dq), 64'(b.dq));
            end
        end else if (!prev_ce_n) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected id=%0d actual rd=%h required=no completion", id, rdata);
            end else begin
                d = done_q.pop_front();
                chk("done_id", 64'(id), 64'(d.id));
                chk("done_ready", 64'(rdy), 64'd1);
                chk("read_data", rdata, d.rd);
            end
        end
    endtask

    logic prev1 = 1'b1, prev2 = 1'b1;

    always @(negedge clk) begin
        if (rst) prev1 = 1'b1;
        else begin
            mon(1'b0, ce1, {we1, oe1, ub1, lb1}, sa1, dq1, ready1, rdata1, prev1);
            prev1 = ce1;
        end
    end

    always @(negedge clk) begin
        if (rst) prev2 = 1'b1;
        else begin
            mon(1'b1, ce2, {we2, oe2, ub2, lb2}, sa2, dq2, ready2, rdata2, prev2);
            prev2 = ce2;
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int unsigned i = 0; i < 1024; i++) mem[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready1), 64'd0);
        chk("rst_addr", 64'(sa1), 64'd0);
        chk("rst_ctrl", 64'({we1, ce1, oe1, ub1, lb1}), 64'h1f);
        chk("rst_read_data", rdata1, 64'd0);
        rst = 1'b0;

        exp_write(1'b0, 32'h400, 32'hDEADBEEF, 4'hF, 1, 64'h0);
        run_op(1'b0, 1'b1, 1'b0, 32'h400, 32'hDEADBEEF, 4'hF, 3);
        exp_write(1'b0, 32'h400, 32'h11112222, 4'hF, 1, 64'h0);
        run_op(1'b0, 1'b1, 1'b0, 32'h400, 32'h11112222, 4'hF, 3);
        exp_write(1'b0, 32'h404, 32'h33334444, 4'hF, 1, 64'h0);
        run_op(1'b0, 1'b1, 1'b0, 32'h404, 32'h33334444, 4'hF, 3);
        exp_read(32'h404, 64'h33334444_11112222, 4);
        run_op(1'b0, 1'b0, 1'b1, 32'h404, 32'h0, 4'h0, 5);

        exp_write(1'b0, 32'h408, 32'h55667788, 4'hF, 1, 64'h33334444_11112222);
        run_op(1'b0, 1'b1, 1'b0, 32'h408, 32'h55667788, 4'hF, 3);
        exp_write(1'b0, 32'h408, 32'hAABBCCDD, 4'b0100, 1, 64'h33334444_11112222);
        run_op(1'b0, 1'b1, 1'b0, 32'h408, 32'hAABBCCDD, 4'b0100, 3);
        exp_read(32'h408, 64'h00000000_55BB7788, 4);
        run_op(1'b0, 1'b0, 1'b1, 32'h408, 32'h0, 4'h0, 5);

        exp_write(1'b0, 32'h40C, 32'h0BADF00D, 4'hF, 1, 64'h00000000_55BB7788);
        run_op(1'b0, 1'b1, 1'b1, 32'h40C, 32'h0BADF00D, 4'hF, 3);
        exp_read(32'h40C, 64'h0BADF00D_55BB7788, 4);
        run_op(1'b0, 1'b0, 1'b1, 32'h40C, 32'h0, 4'h0, 5);

        // Abort a line fill in beat 2 with an asynchronous reset.
        exp_read(32'h400, 64'h0, 2);
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 32'h400;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(ready1), 64'd0);
        chk("midrst_addr", 64'(sa1), 64'd0);
        chk("midrst_ctrl", 64'({we1, ce1, oe1, ub1, lb1}), 64'h1f);
        chk("midrst_read_data", rdata1, 64'd0);
        rd1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        exp_read(32'h400, 64'h33334444_11112222, 4);
        run_op(1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 5);

        exp_write(1'b1, 32'h400, 32'h12345678, 4'hF, 3, 64'h0);
        run_op(1'b1, 1'b1, 1'b0, 32'h400, 32'h12345678, 4'hF, 7);

        repeat (3) @(posedge clk);
        #1;
        chk("beat_q_left", 64'(beat_q.size()), 64'd0);
        chk("done_q_left", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
